// File: rtl/gpi_debouncer.sv
`default_nettype none
// ============================================================================
// Module  : gpi_debouncer
// Brief   : N-channel push-button conditioner: 2-flop synchroniser, debounce
//           filter, registered rise/fall pulses and auto-repeat press pulses.
// Revision: 1.0 - initial release
// ============================================================================
module gpi_debouncer #(
   parameter int N_CH             = 4,
   parameter int CLK_PERIOD_ns    = 20,
   parameter int DEBOUNCE_TIME_ns = 10000000,
   parameter int REPEAT_EN        = 1,
   parameter int REPEAT_DELAY_ns  = 500000000,
   parameter int REPEAT_PERIOD_ns = 100000000
) (
   input  logic            clk,
   input  logic            resetn,      // active-high despite the name
   input  logic            turbo_mode,
   input  logic [N_CH-1:0] gpi,
   output logic [N_CH-1:0] level,
   output logic [N_CH-1:0] rise,
   output logic [N_CH-1:0] fall,
   output logic [N_CH-1:0] press
);

   localparam int c_d      = DEBOUNCE_TIME_ns / CLK_PERIOD_ns;
   localparam int c_cw     = (c_d < 1) ? 1 : $clog2(c_d + 1);
   localparam int c_dm1    = (c_d > 0) ? c_d - 1 : 0;
   localparam bit c_bypass = (c_d <= 1);

   localparam int c_rd_raw = REPEAT_DELAY_ns / CLK_PERIOD_ns;
   localparam int c_rp_raw = REPEAT_PERIOD_ns / CLK_PERIOD_ns;
   localparam int c_rd     = (c_rd_raw < 1) ? 1 : c_rd_raw;
   localparam int c_rp     = (c_rp_raw < 1) ? 1 : c_rp_raw;
   localparam int c_rmax   = (c_rd > c_rp) ? c_rd : c_rp;
   localparam int c_rw     = (c_rmax < 2) ? 1 : $clog2(c_rmax);

   typedef enum logic [1:0] {
      ST_IDLE        = 2'd0,
      ST_WAIT_DELAY  = 2'd1,
      ST_WAIT_PERIOD = 2'd2
   } rep_state_t;

   logic [N_CH-1:0] r_sync1;
   logic [N_CH-1:0] r_sync2;

   always_ff @(posedge clk or posedge resetn) begin
      if (resetn) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
      end else begin
         r_sync1 <= gpi;
         r_sync2 <= r_sync1;
      end
   end

   for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
      logic [c_cw-1:0] r_cnt;
      logic            r_level;
      logic            r_rise;
      logic            r_fall;
      logic            w_level_nxt;
      logic            w_rise_ev;
      logic            w_fall_ev;

      // Turbo is looked at combinationally so it commits a pending change on
      // the very edge it is first seen high.
      always_comb begin
         w_level_nxt = r_level;
         if ((r_sync2[gi] != r_level) &&
             (turbo_mode || c_bypass || (r_cnt == c_cw'(c_dm1)))) begin
            w_level_nxt = r_sync2[gi];
         end
      end

      assign w_rise_ev = w_level_nxt & ~r_level;
      assign w_fall_ev = ~w_level_nxt & r_level;

      always_ff @(posedge clk or posedge resetn) begin
         if (resetn) begin
            r_cnt   <= '0;
            r_level <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
         end else begin
            r_level <= w_level_nxt;
            r_rise  <= w_rise_ev;
            r_fall  <= w_fall_ev;
            if ((r_sync2[gi] == r_level) || (w_level_nxt != r_level)) begin
               r_cnt <= '0;
            end else begin
               r_cnt <= r_cnt + 1'b1;
            end
         end
      end

      assign level[gi] = r_level;
      assign rise[gi]  = r_rise;
      assign fall[gi]  = r_fall;

      if (REPEAT_EN != 0) begin : g_rep
         rep_state_t      r_state;
         rep_state_t      w_state_nxt;
         logic [c_rw-1:0] r_rcnt;
         logic [c_rw-1:0] w_rcnt_nxt;
         logic            r_press;
         logic            w_press_nxt;

         always_ff @(posedge clk or posedge resetn) begin
            if (resetn) begin
               r_state <= ST_IDLE;
               r_rcnt  <= '0;
               r_press <= 1'b0;
            end else begin
               r_state <= w_state_nxt;
               r_rcnt  <= w_rcnt_nxt;
               r_press <= w_press_nxt;
            end
         end

         // Events are taken from the next-level terms so press lines up
         // with the registered rise pulse.
         always_comb begin
            w_state_nxt = r_state;
            w_rcnt_nxt  = r_rcnt;
            w_press_nxt = 1'b0;
            if (w_fall_ev) begin
               w_state_nxt = ST_IDLE;
               w_rcnt_nxt  = '0;
            end else begin
               case (r_state)
                  ST_IDLE: begin
                     if (w_rise_ev) begin
                        w_press_nxt = 1'b1;
                        w_state_nxt = ST_WAIT_DELAY;
                        w_rcnt_nxt  = '0;
                     end
                  end
                  ST_WAIT_DELAY: begin
                     if (r_rcnt == c_rw'(c_rd - 1)) begin
                        w_press_nxt = 1'b1;
                        w_state_nxt = ST_WAIT_PERIOD;
                        w_rcnt_nxt  = '0;
                     end else begin
                        w_rcnt_nxt = r_rcnt + 1'b1;
                     end
                  end
                  ST_WAIT_PERIOD: begin
                     if (r_rcnt == c_rw'(c_rp - 1)) begin
                        w_press_nxt = 1'b1;
                        w_rcnt_nxt  = '0;
                     end else begin
                        w_rcnt_nxt = r_rcnt + 1'b1;
                     end
                  end
                  default: begin
                     w_state_nxt = ST_IDLE;
                     w_rcnt_nxt  = '0;
                  end
               endcase
            end
         end

         assign press[gi] = r_press;
      end else begin : g_norep
         assign press[gi] = r_rise;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_gpi_debouncer.sv
`default_nettype none
// ============================================================================
// Module  : tb_gpi_debouncer
// Brief   : Directed self-checking bench for gpi_debouncer (D=5, RD=20, RP=10).
// Revision: 1.0 - initial release
// ============================================================================
module tb_gpi_debouncer;

   logic       clk;
   logic       resetn;
   logic       turbo_mode;
   logic [3:0] gpi;
   logic [3:0] level, rise, fall, press;
   logic [3:0] level_nr, rise_nr, fall_nr, press_nr;

   int n_chk;
   int n_pass;

   gpi_debouncer #(
      .N_CH(4), .CLK_PERIOD_ns(20), .DEBOUNCE_TIME_ns(100), .REPEAT_EN(1),
      .REPEAT_DELAY_ns(400), .REPEAT_PERIOD_ns(200)
   ) dut (
      .clk(clk), .resetn(resetn), .turbo_mode(turbo_mode), .gpi(gpi),
      .level(level), .rise(rise), .fall(fall), .press(press)
   );

   gpi_debouncer #(
      .N_CH(4), .CLK_PERIOD_ns(20), .DEBOUNCE_TIME_ns(100), .REPEAT_EN(0),
      .REPEAT_DELAY_ns(400), .REPEAT_PERIOD_ns(200)
   ) dut_nr (
      .clk(clk), .resetn(resetn), .turbo_mode(turbo_mode), .gpi(gpi),
      .level(level_nr), .rise(rise_nr), .fall(fall_nr), .press(press_nr)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end else begin
         n_pass++;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int n_press;
      int n_press_nr;
      int n_coinc_bad;
      n_chk      = 0;
      n_pass     = 0;
      resetn     = 1'b0;
      turbo_mode = 1'b0;
      gpi        = 4'b0000;

      // 1: asynchronous reset with a key held, then release
      #3;
      resetn = 1'b1;
      gpi    = 4'b1000;
      #2;
      check("t1_async_level", level, 4'h0);
      check("t1_async_rise",  rise,  4'h0);
      check("t1_async_fall",  fall,  4'h0);
      check("t1_async_press", press, 4'h0);
      repeat (3) tick();
      check("t1_held_level", level, 4'h0);
      check("t1_held_press", press, 4'h0);
      resetn = 1'b0;
      // post-reset edge 1 samples gpi; the level appears 6 edges later
      for (int e = 1; e <= 10; e++) begin
         tick();
         check($sformatf("t1_level_e%0d", e), level, (e >= 7) ? 4'b1000 : 4'b0000);
         check($sformatf("t1_rise_e%0d", e),  rise,  (e == 7) ? 4'b1000 : 4'b0000);
         check($sformatf("t1_press_e%0d", e), press, (e == 7) ? 4'b1000 : 4'b0000);
         check($sformatf("t1_fall_e%0d", e),  fall,  4'h0);
      end

      // 2: bouncing on channel 0, then a clean press
      for (int k = 0; k < 4; k++) begin
         gpi[0] = (k % 2 == 0);
         repeat (2) begin
            tick();
            check($sformatf("t2_bounce_k%0d", k),
                  {29'd0, level[0], rise[0], press[0]}, 32'd0);
         end
      end
      gpi[0] = 1'b1;
      for (int e = 1; e <= 9; e++) begin
         tick();
         check($sformatf("t2_level_e%0d", e), level[0], e >= 7);
         check($sformatf("t2_rise_e%0d", e),  rise[0],  e == 7);
      end

      // 3: auto-repeat on channel 1; release so the level drops at t+55
      gpi[1] = 1'b1;
      for (int e = 1; e <= 7; e++) begin
         tick();
         check($sformatf("t3_level_e%0d", e), level[1], e == 7);
         check($sformatf("t3_press_e%0d", e), press[1], e == 7);
      end
      for (int k = 1; k <= 70; k++) begin
         tick();
         check($sformatf("t3_press_k%0d", k), press[1],
               (k == 20) || (k == 30) || (k == 40) || (k == 50));
         check($sformatf("t3_fall_k%0d", k),  fall[1], k == 55);
         check($sformatf("t3_level_k%0d", k), level[1], k < 55);
         check($sformatf("t3_rise_k%0d", k),  rise[1], 1'b0);
         if (k == 48) gpi[1] = 1'b0;
      end

      // 4: turbo single-cycle pulse on channel 2
      turbo_mode = 1'b1;
      gpi[2]     = 1'b1;
      for (int e = 1; e <= 6; e++) begin
         tick();
         if (e == 1) gpi[2] = 1'b0;
         check($sformatf("t4_level_e%0d", e), level[2], e == 3);
         check($sformatf("t4_rise_e%0d", e),  rise[2],  e == 3);
         check($sformatf("t4_fall_e%0d", e),  fall[2],  e == 4);
         check($sformatf("t4_press_e%0d", e), press[2], e == 3);
      end
      // turbo raised while a mismatch is still counting
      turbo_mode = 1'b0;
      repeat (3) tick();
      gpi[2] = 1'b1;
      for (int e = 1; e <= 5; e++) begin
         tick();
         if (e == 4) turbo_mode = 1'b1;
         check($sformatf("t4m_level_e%0d", e), level[2], e == 5);
      end
      gpi[2] = 1'b0;
      for (int e = 1; e <= 3; e++) begin
         tick();
         check($sformatf("t4m_fall_e%0d", e), fall[2], e == 3);
      end
      turbo_mode = 1'b0;
      repeat (2) tick();

      // 5: reset while ch0 repeats and ch1 is mid-count
      gpi[1] = 1'b1;
      repeat (4) tick();
      check("t5_pre_level", level, 4'b1001);
      resetn = 1'b1;
      #2;
      check("t5_rst_level", level, 4'h0);
      check("t5_rst_rise",  rise,  4'h0);
      check("t5_rst_fall",  fall,  4'h0);
      check("t5_rst_press", press, 4'h0);
      gpi = 4'b0000;
      repeat (2) tick();
      resetn = 1'b0;
      for (int e = 1; e <= 40; e++) begin
         tick();
         check($sformatf("t5_quiet_e%0d", e), level | rise | fall | press, 4'h0);
      end

      // 6: REPEAT_EN=0 gives one press per key-down; REPEAT_EN=1 repeats
      n_press     = 0;
      n_press_nr  = 0;
      n_coinc_bad = 0;
      gpi[0] = 1'b1;
      for (int e = 1; e <= 100; e++) begin
         tick();
         if (press[0]) n_press++;
         if (press_nr[0]) n_press_nr++;
         if (press_nr[0] !== rise_nr[0]) n_coinc_bad++;
      end
      check("t6_nr_press_count", n_press_nr, 1);
      check("t6_nr_coincident",  n_coinc_bad, 0);
      check("t6_nr_level",       level_nr[0], 1'b1);
      check("t6_rep_press_count", n_press, 9);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
